// File: rtl/spi_controller.sv
// spi_controller: memory-mapped SPI master (mode 0) for the rv32i_system MMU.
//
// Accepts one 8/16/24-bit transfer per i_valid/i_ready handshake, shifts it
// out MSB first on spi_mosi while shifting spi_miso into a receive word, and
// returns that word with a one-cycle o_valid pulse.
//
// Handshake: a request is taken on any posedge where i_valid && i_ready.
// i_ready is high only while idle; i_valid while busy is ignored and never
// queued. o_valid is a single-cycle pulse and is the sole qualifier of o_data.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   i_data, i_mode    transmit word (right-justified) and length select
//                     (0=8, 1=16, 2=24, 3=8 bits)
//   i_valid, i_ready  request handshake
//   o_data, o_valid   received word (upper bits zero) and its strobe
//   spi_clk, spi_mosi, spi_miso, spi_csb   SPI pins (spi_miso already in clk domain)
//   dbg_state         current FSM state, for checkers and debug
module spi_controller #(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAX_BITS-1:0] i_data,
  input  logic [1:0]          i_mode,
  input  logic                i_valid,
  output logic                i_ready,
  output logic [MAX_BITS-1:0] o_data,
  output logic                o_valid,
  output logic                spi_clk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic                spi_csb,
  output logic [2:0]          dbg_state
);

  localparam int PW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [MAX_BITS-1:0] tx_q, tx_d;
  logic [MAX_BITS-1:0] rx_q, rx_d;
  logic [MAX_BITS-1:0] o_data_q, o_data_d;
  logic                mosi_q, mosi_d;

  logic       phase_last;
  logic [4:0] len;
  logic [4:0] nxt_idx;

  assign phase_last = (phase_q == PW'(1));
  // Mode 3 is reserved and falls through to 8 bits.
  assign len = (i_mode == 2'd1) ? 5'd16 : (i_mode == 2'd2) ? 5'd24 : 5'd8;
  // Index of the bit presented after the current one completes.
  assign nxt_idx = bit_cnt_q - 5'd2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      o_data_q  <= '0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      o_data_q  <= o_data_d;
      mosi_q    <= mosi_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_SETUP;
      S_SETUP: if (phase_last) state_d = S_HIGH;
      S_HIGH:  if (phase_last) state_d = S_LOW;
      // bit_cnt was decremented on entry to LOW, so zero means the last bit is out.
      S_LOW:   if (phase_last) state_d = (bit_cnt_q == 5'd0) ? S_DONE : S_HIGH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: phase timer, bit counter, shift words
  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    o_data_d  = o_data_q;
    mosi_d    = mosi_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          tx_d      = i_data;
          bit_cnt_d = len;
          rx_d      = '0;
          mosi_d    = i_data[len - 5'd1];
          phase_d   = PW'(CLK_DIV);
        end
      end
      S_SETUP: begin
        if (phase_last) begin
          phase_d = PW'(CLK_DIV);
          // spi_clk rises on this edge: capture the slave's bit.
          rx_d    = {rx_q[MAX_BITS-2:0], spi_miso};
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      S_HIGH: begin
        if (phase_last) begin
          phase_d   = PW'(CLK_DIV);
          bit_cnt_d = bit_cnt_q - 5'd1;
          mosi_d    = (bit_cnt_q == 5'd1) ? 1'b0 : tx_q[nxt_idx];
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      S_LOW: begin
        if (phase_last) begin
          if (bit_cnt_q == 5'd0) begin
            phase_d  = '0;
            o_data_d = rx_q;
          end else begin
            phase_d = PW'(CLK_DIV);
            rx_d    = {rx_q[MAX_BITS-2:0], spi_miso};
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      default: begin
        phase_d = '0;
      end
    endcase
  end

  // Outputs decoded from state so an async reset drives the pins at once.
  always_comb begin
    i_ready   = (state_q == S_IDLE);
    o_valid   = (state_q == S_DONE);
    spi_clk   = (state_q == S_HIGH);
    spi_csb   = !((state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW));
    spi_mosi  = mosi_q;
    o_data    = o_data_q;
    dbg_state = state_q;
  end

endmodule
